// File: rtl/multicycle_controller.sv
// multicycle_controller: RISC-V multicycle control FSM with cache handshake and retired-instruction counter.
// Define MULTICYCLE_ITYPE_JAL_EN to add the EXECI and JAL states. Rev 1.0
`default_nettype none

module multicycle_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       op_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic             mem_req_o,
  output logic             mem_write_o,
  output logic             adr_src_o,
  output logic             ir_write_o,
  output logic             pc_write_o,
  output logic             reg_write_o,
  output logic [1:0]       alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [1:0]       result_src_o,
  output logic [1:0]       alu_op_o,
  output logic             retire_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] instret_o
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } state_t;

  state_t           state_q, state_d, cur_state;
  logic [CNT_W-1:0] instret_q;
  logic             ready;
  logic             pc_update;
  logic             branch;

  // In reset the outputs look like FETCH waiting on the cache, whatever state we were in.
  assign cur_state = rst_n ? state_q : FETCH;
  assign ready     = mem_ready_i & rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire_o) instret_q <= instret_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    mem_req_o    = 1'b0;
    mem_write_o  = 1'b0;
    adr_src_o    = 1'b0;
    ir_write_o   = 1'b0;
    reg_write_o  = 1'b0;
    alu_src_a_o  = 2'b00;
    alu_src_b_o  = 2'b00;
    result_src_o = 2'b00;
    alu_op_o     = 2'b00;
    retire_o     = 1'b0;
    illegal_o    = 1'b0;
    pc_update    = 1'b0;
    branch       = 1'b0;
    case (cur_state)
      FETCH: begin
        mem_req_o    = 1'b1;
        alu_src_b_o  = 2'b10;
        result_src_o = 2'b10;
        ir_write_o   = ready;
        pc_update    = ready;
        if (ready) state_d = DECODE;
      end
      DECODE: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b01;
        case (op_i)
          7'b0000011, 7'b0100011: state_d = MEMADR;
          7'b0110011:             state_d = EXECR;
          7'b1100011:             state_d = BEQ;
`ifdef MULTICYCLE_ITYPE_JAL_EN
          7'b0010011:             state_d = EXECI;
          7'b1101111:             state_d = JAL;
`endif
          default: begin
            illegal_o = 1'b1;
            retire_o  = 1'b1;
            state_d   = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
        state_d     = op_i[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        mem_req_o = 1'b1;
        adr_src_o = 1'b1;
        if (ready) state_d = MEMWB;
      end
      MEMWB: begin
        result_src_o = 2'b01;
        reg_write_o  = 1'b1;
        retire_o     = 1'b1;
        state_d      = FETCH;
      end
      MEMWRITE: begin
        mem_req_o   = 1'b1;
        mem_write_o = 1'b1;
        adr_src_o   = 1'b1;
        if (ready) begin
          retire_o = 1'b1;
          state_d  = FETCH;
        end
      end
      EXECR, EXECI: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = (cur_state == EXECI) ? 2'b01 : 2'b00;
        alu_op_o    = 2'b10;
        state_d     = ALUWB;
      end
      ALUWB: begin
        reg_write_o = 1'b1;
        retire_o    = 1'b1;
        state_d     = FETCH;
      end
      BEQ: begin
        alu_src_a_o = 2'b10;
        alu_op_o    = 2'b01;
        branch      = 1'b1;
        retire_o    = 1'b1;
        state_d     = FETCH;
      end
      JAL: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b10;
        pc_update   = 1'b1;
        state_d     = ALUWB;
      end
      default: state_d = FETCH;
    endcase
    pc_write_o = pc_update | (branch & zero_i);
  end

  assign instret_o = instret_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: table-driven per-cycle output checks plus a hand-written sw wait-state sequence.
// A second instance with a 2-bit counter exercises instret wrap-around. Rev 1.0
`default_nettype none

module tb_multicycle_controller;

  // Expected output word: {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
  //                        alu_src_a[1:0], alu_src_b[1:0], result_src[1:0], alu_op[1:0], retire, illegal}
  localparam logic [15:0] F_NR   = 16'h80A0;
  localparam logic [15:0] F_R    = 16'h98A0;
  localparam logic [15:0] DEC    = 16'h0140;
  localparam logic [15:0] DEC_IL = 16'h0143;
  localparam logic [15:0] MADR   = 16'h0240;
  localparam logic [15:0] MRD    = 16'hA000;
  localparam logic [15:0] MWB    = 16'h0412;
  localparam logic [15:0] MWR_NR = 16'hE000;
  localparam logic [15:0] MWR_R  = 16'hE002;
  localparam logic [15:0] EXR    = 16'h0208;
  localparam logic [15:0] EXI    = 16'h0248;
  localparam logic [15:0] AWB    = 16'h0402;
  localparam logic [15:0] BEQ_Z0 = 16'h0206;
  localparam logic [15:0] BEQ_Z1 = 16'h0A06;
  localparam logic [15:0] JALS   = 16'h0980;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  typedef struct {
    logic        rst_n;
    logic [6:0]  op;
    logic        zero;
    logic        rdy;
    logic [15:0] exp;
    logic [31:0] cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n, zero, mem_ready;
  logic [6:0]  op;
  logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, retire, illegal;
  logic [1:0]  alu_src_a, alu_src_b, result_src, alu_op;
  logic [31:0] instret;

  logic        s_mem_req, s_mem_write, s_adr_src, s_ir_write, s_pc_write, s_reg_write, s_retire, s_illegal;
  logic [1:0]  s_alu_src_a, s_alu_src_b, s_result_src, s_alu_op;
  logic [1:0]  s_instret;

  int          n_vec  = 0;
  int          n_fail = 0;
  logic [31:0] ec     = 0;
  vec_t        vecs[$];

  always #5 clk = ~clk;

  multicycle_controller #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .op_i(op), .zero_i(zero), .mem_ready_i(mem_ready),
    .mem_req_o(mem_req), .mem_write_o(mem_write), .adr_src_o(adr_src), .ir_write_o(ir_write),
    .pc_write_o(pc_write), .reg_write_o(reg_write), .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b),
    .result_src_o(result_src), .alu_op_o(alu_op), .retire_o(retire), .illegal_o(illegal),
    .instret_o(instret)
  );

  multicycle_controller #(.CNT_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .op_i(op), .zero_i(zero), .mem_ready_i(mem_ready),
    .mem_req_o(s_mem_req), .mem_write_o(s_mem_write), .adr_src_o(s_adr_src), .ir_write_o(s_ir_write),
    .pc_write_o(s_pc_write), .reg_write_o(s_reg_write), .alu_src_a_o(s_alu_src_a), .alu_src_b_o(s_alu_src_b),
    .result_src_o(s_result_src), .alu_op_o(s_alu_op), .retire_o(s_retire), .illegal_o(s_illegal),
    .instret_o(s_instret)
  );

  wire [15:0] obs = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                     alu_src_a, alu_src_b, result_src, alu_op, retire, illegal};

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Records the counter value expected during this cycle, then advances the model.
  task automatic add(input logic r, input logic [6:0] o, input logic z, input logic rd, input logic [15:0] e);
    vecs.push_back('{r, o, z, rd, e, ec});
    if (!r) ec = 0;
    else if (e[1]) ec = ec + 1;
  endtask

  initial begin
    int   cycles;
    logic done;

    // R-type, zero wait states
    add(0, OP_R, 0, 1, F_NR);
    add(1, OP_R, 0, 1, F_R);
    add(1, OP_R, 0, 1, DEC);
    add(1, OP_R, 0, 1, EXR);
    add(1, OP_R, 0, 1, AWB);
    // lw with three wait cycles in MEMREAD
    add(1, OP_LW, 0, 1, F_R);
    add(1, OP_LW, 0, 1, DEC);
    add(1, OP_LW, 0, 1, MADR);
    add(1, OP_LW, 0, 0, MRD);
    add(1, OP_LW, 0, 0, MRD);
    add(1, OP_LW, 0, 0, MRD);
    add(1, OP_LW, 0, 1, MRD);
    add(1, OP_LW, 0, 1, MWB);
    // beq taken, then not taken
    add(1, OP_BEQ, 1, 1, F_R);
    add(1, OP_BEQ, 1, 1, DEC);
    add(1, OP_BEQ, 1, 1, BEQ_Z1);
    add(1, OP_BEQ, 0, 1, F_R);
    add(1, OP_BEQ, 0, 1, DEC);
    add(1, OP_BEQ, 0, 1, BEQ_Z0);
    // fetch stall with zero high must not write the PC
    add(1, OP_BAD, 1, 0, F_NR);
    add(1, OP_BAD, 0, 1, F_R);
    add(1, OP_BAD, 0, 1, DEC_IL);
    // I-type and jal depend on the build option
    add(1, OP_I, 0, 1, F_R);
`ifdef MULTICYCLE_ITYPE_JAL_EN
    add(1, OP_I, 0, 1, DEC);
    add(1, OP_I, 0, 1, EXI);
    add(1, OP_I, 0, 1, AWB);
`else
    add(1, OP_I, 0, 1, DEC_IL);
`endif
    add(1, OP_JAL, 0, 1, F_R);
`ifdef MULTICYCLE_ITYPE_JAL_EN
    add(1, OP_JAL, 0, 1, DEC);
    add(1, OP_JAL, 0, 1, JALS);
    add(1, OP_JAL, 0, 1, AWB);
`else
    add(1, OP_JAL, 0, 1, DEC_IL);
`endif
    // sw aborted by reset while waiting in MEMWRITE; ready is high during reset but must be ignored
    add(1, OP_SW, 0, 1, F_R);
    add(1, OP_SW, 0, 1, DEC);
    add(1, OP_SW, 0, 1, MADR);
    add(1, OP_SW, 0, 0, MWR_NR);
    add(0, OP_SW, 0, 1, F_NR);
    add(1, OP_SW, 0, 0, F_NR);
    add(1, OP_SW, 0, 0, F_NR);

    rst_n = 1'b0; op = 7'd0; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n = vecs[i].rst_n; op = vecs[i].op; zero = vecs[i].zero; mem_ready = vecs[i].rdy;
      #1;
      chk($sformatf("vec%0d outputs", i), {16'd0, obs}, {16'd0, vecs[i].exp});
      chk($sformatf("vec%0d instret", i), instret, vecs[i].cnt);
      chk($sformatf("vec%0d instret_w2", i), {30'd0, s_instret}, {30'd0, vecs[i].cnt[1:0]});
    end

    // sw with two wait states: request and address held, 6 cycles total, single retire
    cycles = 0;
    done   = 1'b0;
    for (int k = 0; k < 12 && !done; k++) begin
      @(negedge clk);
      rst_n = 1'b1; op = OP_SW; zero = 1'b0;
      mem_ready = !(k == 3 || k == 4);
      #1;
      if (k >= 3) chk($sformatf("sw hold c%0d", k), {29'd0, mem_req, mem_write, adr_src}, 32'd7);
      if (retire) begin
        done   = 1'b1;
        cycles = k + 1;
      end
    end
    if (!done) chk("sw retire timeout", 32'd0, 32'd1);
    else chk("sw latency", cycles, 32'd6);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk("sw instret", instret, 32'd1);
    chk("sw retire single", {31'd0, retire}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multicycle_controller.md
# multicycle_controller

Multicycle control FSM for the RISC-V core. It sequences each instruction through fetch, decode, execute, memory and writeback, and drives the datapath muxes, the register-file and IR write enables, and `ALUOp` into the ALU decoder. It also runs a request/ready handshake with the unified cache so that misses stall the sequence. A retired-instruction counter is included for performance monitoring.

## Interface
Parameters:
- `CNT_W`, 32, width of the retired-instruction counter.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset, sampled on the `clk` rising edge.
- `op` in 7: opcode from the IR.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: cache has completed the current request this cycle.
- `mem_req` out 1: cache access request; held until `mem_ready`.
- `mem_write` out 1: write qualifier for `mem_req`.
- `adr_src` out 1: 0 selects PC, 1 selects the ALU result register, as the memory address.
- `ir_write` out 1: load the IR and OldPC.
- `pc_write` out 1: load the PC. Equals `pc_update | (branch & zero)`.
- `reg_write` out 1: register-file write enable.
- `alu_src_a` out 2: 00 PC, 01 OldPC, 10 rs1.
- `alu_src_b` out 2: 00 rs2, 01 immediate, 10 constant 4.
- `result_src` out 2: 00 ALUOut, 01 read data, 10 ALU result.
- `alu_op` out 2: 00 add, 01 sub, 10 funct-decoded.
- `retire` out 1: one-cycle pulse when an instruction completes.
- `illegal` out 1: one-cycle pulse when DECODE sees an unsupported opcode.
- `instret` out CNT_W: count of retired instructions.

## Operation
States and their encodings:
- FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10.

Outputs not listed for a state are 0.
- FETCH: `mem_req`=1, `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, `alu_op`=00, `result_src`=10. `ir_write` and `pc_update` equal `mem_ready`. Stay in FETCH until `mem_ready`, then go to DECODE.
- DECODE: `alu_src_a`=01, `alu_src_b`=01, `alu_op`=00 (computes the branch target). Next state by `op`:
  - 0000011 or 0100011 go to MEMADR.
  - 0110011 goes to EXECR.
  - 1100011 goes to BEQ.
  - 0010011 goes to EXECI (only with the macro enabled).
  - 1101111 goes to JAL (only with the macro enabled).
  - Any other opcode pulses `illegal` and `retire`, then goes to FETCH.
- MEMADR: `alu_src_a`=10, `alu_src_b`=01, `alu_op`=00. Goes to MEMREAD if `op[5]`=0, otherwise MEMWRITE.
- MEMREAD: `mem_req`=1, `adr_src`=1. Waits for `mem_ready`, then goes to MEMWB.
- MEMWB: `result_src`=01, `reg_write`=1, `retire`=1. Goes to FETCH.
- MEMWRITE: `mem_req`=1, `mem_write`=1, `adr_src`=1. Waits for `mem_ready`, then pulses `retire` and goes to FETCH.
- EXECR: `alu_src_a`=10, `alu_src_b`=00, `alu_op`=10. Goes to ALUWB.
- EXECI: as EXECR but with `alu_src_b`=01. Goes to ALUWB.
- ALUWB: `result_src`=00, `reg_write`=1, `retire`=1. Goes to FETCH.
- BEQ: `alu_src_a`=10, `alu_src_b`=00, `alu_op`=01, `result_src`=00, `branch`=1, `retire`=1. Goes to FETCH.
- JAL: `alu_src_a`=01, `alu_src_b`=10, `alu_op`=00, `result_src`=00, `pc_update`=1. Goes to ALUWB.

Counter:
- `instret` increments by 1 in every cycle where `retire`=1.
- It wraps modulo 2^CNT_W with no saturation.

## Timing
- Reset: with `rst_n`=0 at an edge, the state becomes FETCH and `instret` becomes 0.
- While in reset, outputs take the FETCH values with `mem_ready` forced low: `mem_req`=1 and every write enable is 0. `retire` and `illegal` are 0.
- Reset mid-operation (for example during MEMWRITE) aborts the instruction. `mem_req` stays high, because FETCH issues a new request; the cache must accept a request change without a completed handshake.
- Handshake: the address and `mem_write` are stable from the cycle `mem_req` rises until the cycle `mem_ready` is seen. A transfer completes in the cycle where `mem_req & mem_ready`.
- `mem_ready` while `mem_req`=0 is ignored.
- Latency with zero wait states:
  - lw: 5 cycles.
  - sw, R-type, I-type and jal: 4 cycles each.
  - beq: 3 cycles.
- Each wait cycle on `mem_ready` adds one cycle.
- `retire` is asserted in exactly one cycle per instruction. `instret` reflects that retire from the following cycle.

## Configuration
- `MULTICYCLE_ITYPE_JAL_EN` defined: the EXECI and JAL states exist, and opcodes 0010011 and 1101111 decode to them.
- Not defined: those two opcodes are illegal. The state register stays 4 bits and encodings 7 and 10 are unreachable.

## Test plan
- Reset, then an R-type add (`op`=0110011) with `mem_ready` held at 1: the state sequence is FETCH, DECODE, EXECR, ALUWB, FETCH. `alu_op`=10 in EXECR, `reg_write`=1 in ALUWB, and `instret`=1 after it.
- lw (0000011) with `mem_ready` low for 3 cycles in MEMREAD: `mem_req`=1 and `adr_src`=1 are held for 4 cycles, MEMWB follows, and the instruction takes 8 cycles in total.
- beq with `zero`=1, then with `zero`=0: `pc_write`=1 in BEQ for the first and 0 for the second, with `alu_op`=01 in both.
- sw with `rst_n` pulled to 0 during MEMWRITE: the next state is FETCH, `mem_write`=0, `instret` is 0, and `retire` never pulses.
- `op`=1111111 in DECODE: `illegal` and `retire` each pulse for 1 cycle, and the FSM returns to FETCH.
- jal with the macro on: JAL has `pc_write`=1, then ALUWB follows. With the macro off, `illegal` pulses. Separately, force `instret` to 2^CNT_W−1, retire once, and check it wraps to 0.
